turf_event_header_reader: RTL
=============================

# turf_event_header_reader

Consumer side of the TURF event-header buffer. The event generator writes header words into a 4-buffer header RAM (address = {buffer[1:0], word[5:0]}) and pulses done. This block queues completed buffers, reads words 0x00..NUM_WORDS-1 of each one, and streams them out over a valid/ready port to the readout interface. After the last word is accepted it pulses a release so the buffer hold can be cleared.

## Interface

**Parameters**
- `NUM_WORDS`, default 22: header words per event (0x00..0x15); legal range 1..64.
- `QUEUE_DEPTH`, default 4: number of pending buffer IDs held; power of 2.

**Ports**
- `clk33_i`: in, 1. Single clock for the whole block.
- `rst_i`: in, 1. Reset, asynchronous and active-high.
- `event_done_i`: in, 1. One-cycle pulse: the header of `event_buffer_i` is complete.
- `event_buffer_i`: in, 2. Buffer ID; sampled only when `event_done_i` = 1.
- `hdr_addr_o`: out, 8. Header RAM read address = {buffer, word index}.
- `hdr_rd_o`: out, 1. Header RAM read enable.
- `hdr_dat_i`: in, 16. RAM read data; valid exactly 1 cycle after `hdr_rd_o`.
- `m_dat_o`: out, 16. Output header word.
- `m_valid_o`: out, 1. `m_dat_o` is valid.
- `m_ready_i`: in, 1. Downstream accepts the word.
- `m_first_o`: out, 1. Current word is word 0.
- `m_last_o`: out, 1. Current word is word NUM_WORDS-1.
- `buffer_release_o`: out, 1. One-cycle pulse: the buffer has been fully read out.
- `buffer_release_id_o`: out, 2. ID of the released buffer; held until the next release.
- `pending_o`: out, log2(QUEUE_DEPTH)+1. Number of queued IDs, excluding the buffer currently being read.
- `overflow_o`: out, 1. Sticky; a done pulse was dropped.

## Operation

**Queue**
- Circular FIFO of 2-bit IDs.
- A push happens on `event_done_i`.
- A pop happens when the FSM leaves IDLE.
- Push to a full queue with no pop in the same cycle: the ID is dropped and `overflow_o` is set.
- Push and pop in the same cycle: both take effect; this holds when full and when empty-with-pop-impossible.
- No duplicate-ID checking.

**FSM states**
- IDLE: if the queue is non-empty, pop the ID into `cur_buf`, clear `word_idx`, go to READ.
- READ: `hdr_rd_o` = 1, `hdr_addr_o` = {cur_buf, word_idx}; go to CAPTURE.
- CAPTURE: register `hdr_dat_i` into `m_dat_o`; go to PRESENT.
- PRESENT: `m_valid_o` = 1.
  - On `m_ready_i` with word_idx = NUM_WORDS-1, go to RELEASE.
  - On `m_ready_i` otherwise, increment word_idx and go to READ.
- RELEASE: `buffer_release_o` = 1 and `buffer_release_id_o` = cur_buf; go to IDLE.

**Output rules**
- `m_dat_o`, `m_first_o` and `m_last_o` are stable while `m_valid_o` = 1 and `m_ready_i` = 0.
- `m_first_o` = PRESENT and word_idx = 0.
- `m_last_o` = PRESENT and word_idx = NUM_WORDS-1.
- word_idx is 6 bits and never exceeds NUM_WORDS-1.

**Reset**
- Reset mid-event abandons the event: no release pulse, the queue is emptied, and `overflow_o` is cleared.

## Timing

**Reset values**
- All outputs are 0.
- FSM is in IDLE, the queue is empty, and `pending_o` = 0.

**Latency**
- Done at cycle N with an empty queue and the FSM in IDLE:
  - `pending_o` = 1 at N+1.
  - IDLE pops at N+1.
  - READ at N+2.
  - CAPTURE at N+3.
  - `m_valid_o` rises at N+4.

**Throughput**
- One word per 3 cycles with `m_ready_i` held at 1.
- One event takes 3·NUM_WORDS+2 cycles from leaving IDLE back to IDLE.

**Back-to-back events**
- A new event starts in the cycle after RELEASE: IDLE pops immediately when the queue is non-empty.

**RAM**
- `hdr_rd_o` is combinational from state; `hdr_addr_o` is registered.
- Reads occur only in READ.

## Structure

**Shared package `turf_readout_pkg`**
- `HDR_NUM_WORDS` = 22.
- Header word offsets: EVID_LO = 0x10, EVID_HI = 0x11, BUF_ID = 0x14, HOLDS = 0x15.
- `buf_id_t` (2-bit).
- FSM state enum.

**Sub-module**
- `turf_buffer_id_fifo`: the ID queue, with push, pop, full, empty, count and overflow.

## Test plan

- **Single event.** Preload RAM buffer 2 with word k = 0xA000+k. Pulse done with ID 2; hold ready = 1.
  - 22 words 0xA000..0xA015 appear, with first on 0xA000 and last on 0xA015.
  - `hdr_addr_o` runs 0x80..0x95.
  - The release pulse carries ID 2.
  - The first valid is at N+4.
- **Backpressure.** Drop ready for 5 cycles on word 7: `m_dat_o` holds 0xA007 with valid high, and no extra RAM read occurs.
- **Queue ordering.** Send done pulses for IDs 1, 3, 0 on consecutive cycles.
  - Readout order is 1, 3, 0, with three releases in that order.
  - `pending_o` peaks at 2.
- **Overflow.** Hold ready = 0 during event 0 and send 5 further done pulses (QUEUE_DEPTH = 4).
  - `overflow_o` = 1 and `pending_o` = 4.
  - After ready is released, exactly 5 events are streamed.
- **Simultaneous push and pop.** With the queue full, send a done pulse in the IDLE pop cycle: no overflow, and `pending_o` stays at 4.
- **Reset mid-stream.** Assert `rst_i` during word 10 of an event.
  - All outputs go to 0 immediately; no release pulse.
  - A later done pulse streams from word 0.

Source files
------------

// File: rtl/turf_readout_pkg.sv
// Shared definitions for the TURF readout path.
// Holds the header geometry (default word count and offsets of the
// interesting header fields), the buffer ID type, and the state
// encoding of the header reader FSM.
package turf_readout_pkg;

  // Number of header words written per event (0x00..0x15).
  localparam int HDR_NUM_WORDS = 22;

  // Offsets of notable fields inside the header.
  localparam logic [5:0] HDR_EVID_LO = 6'h10;
  localparam logic [5:0] HDR_EVID_HI = 6'h11;
  localparam logic [5:0] HDR_BUF_ID  = 6'h14;
  localparam logic [5:0] HDR_HOLDS   = 6'h15;

  // One of the four header RAM buffers.
  typedef logic [1:0] buf_id_t;

  // Header reader FSM states.
  typedef enum logic [2:0] {
    RD_IDLE,
    RD_READ,
    RD_CAPTURE,
    RD_PRESENT,
    RD_RELEASE
  } rd_state_t;

  // Header RAM address of word 'word' in buffer 'buf_id'.
  function automatic logic [7:0] hdr_word_addr(buf_id_t buf_id, logic [5:0] word);
    return {buf_id, word};
  endfunction

endpackage

// File: rtl/turf_buffer_id_fifo.sv
// Circular FIFO of completed header buffer IDs.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   push      - enqueue push_id (dropped if full and no pop this cycle)
//   push_id   - buffer ID to enqueue
//   pop       - dequeue the head entry (ignored when empty)
//   pop_id    - current head entry
//   empty     - no entries held
//   count     - number of entries held (0..DEPTH)
//   overflow  - sticky, set when a push was dropped
module turf_buffer_id_fifo
  import turf_readout_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  buf_id_t       push_id,
  input  logic          pop,
  output buf_id_t       pop_id,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  buf_id_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign do_push = push && (!full || do_pop);
  assign pop_id  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
      if (push && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/turf_event_header_reader.sv
// Consumer side of the TURF event-header buffer. Completed buffer IDs are
// queued; each one is read word by word from the header RAM and streamed
// out over a valid/ready port, then released.
// Ports:
//   clk33_i, rst_i          - clock, asynchronous active-high reset
//   event_done_i            - pulse: header in event_buffer_i is complete
//   event_buffer_i          - ID of the completed buffer
//   hdr_addr_o, hdr_rd_o    - header RAM read address / enable
//   hdr_dat_i               - RAM data, valid one cycle after hdr_rd_o
//   m_dat_o, m_valid_o      - output word and its valid
//   m_ready_i               - downstream accepts the word
//   m_first_o, m_last_o     - word 0 / word NUM_WORDS-1 markers
//   buffer_release_o        - pulse: buffer fully read out
//   buffer_release_id_o     - ID of the last released buffer
//   pending_o               - queued IDs, excluding the one being read
//   overflow_o              - sticky: a done pulse was dropped
module turf_event_header_reader
  import turf_readout_pkg::*;
#(
  parameter int NUM_WORDS = HDR_NUM_WORDS,
  parameter int QUEUE_DEPTH = 4,
  localparam int PW = $clog2(QUEUE_DEPTH)
) (
  input  logic          clk33_i,
  input  logic          rst_i,
  input  logic          event_done_i,
  input  logic [1:0]    event_buffer_i,
  output logic [7:0]    hdr_addr_o,
  output logic          hdr_rd_o,
  input  logic [15:0]   hdr_dat_i,
  output logic [15:0]   m_dat_o,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic          m_first_o,
  output logic          m_last_o,
  output logic          buffer_release_o,
  output logic [1:0]    buffer_release_id_o,
  output logic [PW:0]   pending_o,
  output logic          overflow_o
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

  rd_state_t  state;
  rd_state_t  next_state;
  buf_id_t    cur_buf;
  buf_id_t    pop_id;
  logic [5:0] word_idx;
  logic       pop;
  logic       fifo_empty;

  turf_buffer_id_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_id_fifo (
    .clk      (clk33_i),
    .rst      (rst_i),
    .push     (event_done_i),
    .push_id  (event_buffer_i),
    .pop      (pop),
    .pop_id   (pop_id),
    .empty    (fifo_empty),
    .count    (pending_o),
    .overflow (overflow_o)
  );

  // State register.
  always_ff @(posedge clk33_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RD_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; the RAM read strobe and queue pop come straight from state.
  always_comb begin
    next_state = state;
    hdr_rd_o   = 1'b0;
    pop        = 1'b0;
    unique case (state)
      RD_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = RD_READ;
        end
      end
      RD_READ: begin
        hdr_rd_o   = 1'b1;
        next_state = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        next_state = RD_PRESENT;
      end
      RD_PRESENT: begin
        if (m_ready_i) begin
          next_state = (word_idx == LAST_IDX) ? RD_RELEASE : RD_READ;
        end
      end
      RD_RELEASE: begin
        next_state = RD_IDLE;
      end
      default: begin
        next_state = RD_IDLE;
      end
    endcase
  end

  // Datapath. The RAM address is registered, so it is loaded on the edge
  // that enters READ: from IDLE with the popped ID, or from PRESENT with
  // the next word index. The release ID is loaded on the edge entering
  // RELEASE so it is already valid during the pulse and then held.
  always_ff @(posedge clk33_i or posedge rst_i) begin
    if (rst_i) begin
      cur_buf             <= '0;
      word_idx            <= '0;
      hdr_addr_o          <= '0;
      m_dat_o             <= '0;
      buffer_release_id_o <= '0;
    end else begin
      if (state == RD_IDLE && pop) begin
        cur_buf    <= pop_id;
        word_idx   <= '0;
        hdr_addr_o <= hdr_word_addr(pop_id, 6'd0);
      end
      if (state == RD_CAPTURE) begin
        m_dat_o <= hdr_dat_i;
      end
      if (state == RD_PRESENT && m_ready_i) begin
        if (word_idx == LAST_IDX) begin
          buffer_release_id_o <= cur_buf;
        end else begin
          word_idx   <= word_idx + 6'd1;
          hdr_addr_o <= hdr_word_addr(cur_buf, word_idx + 6'd1);
        end
      end
    end
  end

  assign m_valid_o        = (state == RD_PRESENT);
  assign m_first_o        = (state == RD_PRESENT) && (word_idx == 6'd0);
  assign m_last_o         = (state == RD_PRESENT) && (word_idx == LAST_IDX);
  assign buffer_release_o = (state == RD_RELEASE);

endmodule
